// File: rtl/mod3_sched_pkg.sv
// mod3_sched_pkg
//   Shared definitions for the mod-3 serial scheduler: FSM state codes,
//   remainder encodings and the MSB-first next-remainder function.
//   No ports (package).
package mod3_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [1:0] REM0 = 2'd0;
    localparam logic [1:0] REM1 = 2'd1;
    localparam logic [1:0] REM2 = 2'd2;

    // (2*rem + b) mod 3; the unreachable code 3 behaves like REM0.
    function automatic logic [1:0] next_rem(input logic [1:0] rem, input logic b);
        case (rem)
            REM1:    next_rem = b ? REM0 : REM2;
            REM2:    next_rem = b ? REM2 : REM1;
            default: next_rem = b ? REM1 : REM0;
        endcase
    endfunction

endpackage

// File: rtl/mod3_rem_fsm.sv
// mod3_rem_fsm
//   Moore remainder register for a bit-serial divisible-by-3 check.
//   Ports:
//     clk     in   clock, rising edge
//     rst     in   asynchronous active-high reset (rem -> 0)
//     clr     in   synchronous clear to remainder 0 (start of a word)
//     en      in   consume bit_in this cycle
//     bit_in  in   next data bit, MSB first
//     rem     out  current remainder 0..2
module mod3_rem_fsm
    import mod3_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [1:0] rem
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= REM0;
        end else if (clr) begin
            rem <= REM0;
        end else if (en) begin
            rem <= next_rem(rem, bit_in);
        end
    end

endmodule

// File: rtl/mod3_serial_scheduler.sv
// mod3_serial_scheduler
//   Round-robin scheduler sharing one bit-serial mod-3 engine between NREQ
//   requesters. A granted W-bit word is latched, shifted MSB-first through
//   mod3_rem_fsm, and the result (mult3, requester id) is held until taken.
//   Optional feature macro: MOD3_REMAINDER_EN adds output res_rem.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     req_valid  in   per-requester word valid
//     req_data   in   requester i word at [i*W +: W]
//     req_ready  out  one-hot grant, only in IDLE
//     res_valid  out  result valid, held until res_ready
//     res_ready  in   consumer accepts result
//     res_mult3  out  accepted word divisible by 3
//     res_id     out  requester owning the result
//     busy       out  state != IDLE
//     res_rem    out  remainder in DONE, else 0 (MOD3_REMAINDER_EN only)
//
//   state | meaning
//   IDLE  | arbitrating; req_ready grants the round-robin winner
//   SHIFT | one bit per cycle into the remainder FSM, W cycles
//   DONE  | result presented until res_ready
module mod3_serial_scheduler
    import mod3_sched_pkg::*;
#(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_mult3,
    output logic [ID_W-1:0]   res_id,
    output logic              busy
`ifdef MOD3_REMAINDER_EN
    ,
    output logic [1:0]        res_rem
`endif
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic [1:0]       state;
    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id;
    logic [1:0]       rem;
    logic [1:0]       rem_clean;

    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  gnt_idx;
    logic             found;
    logic [NREQ-1:0]  rot;
    int               arb_idx;
    logic [W-1:0]     word_sel;
    logic             accept;

    // Walk rr_ptr, rr_ptr+1, ... (mod NREQ); first valid wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        rot     = '0;
        arb_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
            rot = req_valid >> arb_idx;
            if (!found && rot[0]) begin
                found   = 1'b1;
                grant   = NREQ'(1) << arb_idx;
                gnt_idx = ID_W'(arb_idx);
            end
        end
    end

    // Gated by rst so every output reads 0 while reset is held.
    assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;
    assign accept    = |req_ready;
    assign word_sel  = W'(req_data >> (int'(gnt_idx) * W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
            id     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg <= word_sel;
                        id    <= gnt_idx;
                        cnt   <= CNT_W'(W - 1);
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg <= shreg << 1;
                    if (cnt == '0) state <= ST_DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state  <= ST_IDLE;
                        rr_ptr <= (int'(id) + 1 >= NREQ) ? '0 : id + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mod3_rem_fsm u_rem (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (state == ST_SHIFT),
        .bit_in (shreg[W-1]),
        .rem    (rem)
    );

    assign rem_clean = (rem == 2'd3) ? REM0 : rem;
    assign res_valid = (state == ST_DONE);
    assign res_mult3 = res_valid && (rem_clean == REM0);
    assign res_id    = res_valid ? id : '0;
    assign busy      = (state != ST_IDLE);

`ifdef MOD3_REMAINDER_EN
    assign res_rem   = res_valid ? rem_clean : 2'd0;
`endif

endmodule
